// File: rtl/fsm_vending_machine.sv
// Coin-operated drink vending controller.
// A 4-state credit FSM (0..3 coins) decides dispensing. It takes sprite
// (2 coins) over coffee (1 coin) over a coin insert. Credit LEDs and a
// 7-segment credit display are decoded from the state register.
module fsm_vending_machine #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_coin,
  input  logic       i_coffee,
  input  logic       i_sprite,
  output logic       o_led_coffee,
  output logic       o_led_sprite,
  output logic       o_coffee,
  output logic       o_sprite,
  output logic [1:0] BCD_signal,
  output logic [7:0] o_seg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COIN_1 = 2'd1,
    COIN_2 = 2'd2,
    COIN_3 = 2'd3
  } state_t;

  state_t state;

  // Common-anode segment pattern {dp,g,f,e,d,c,b,a}; dp stays dark.
  function automatic logic [7:0] seg_decode(input logic [1:0] digit);
    logic [7:0] pat;
    case (digit)
      2'd0:    pat = 8'hC0;
      2'd1:    pat = 8'hF9;
      2'd2:    pat = 8'hA4;
      default: pat = 8'hB0;
    endcase
    return pat;
  endfunction

  // Credit FSM with registered one-cycle dispense pulses.
  // rst_n is active-high despite its name; it overrides every input.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      o_coffee <= 1'b0;
      o_sprite <= 1'b0;
    end else begin
      o_coffee <= 1'b0;
      o_sprite <= 1'b0;
      case (state)
        IDLE: begin
          if (i_coin) state <= COIN_1;
        end
        COIN_1: begin
          if (i_coffee) begin
            state    <= IDLE;
            o_coffee <= 1'b1;
          end else if (i_coin) begin
            state <= COIN_2;
          end
        end
        COIN_2: begin
          if (i_sprite) begin
            state    <= IDLE;
            o_sprite <= 1'b1;
          end else if (i_coffee) begin
            state    <= COIN_1;
            o_coffee <= 1'b1;
          end else if (i_coin) begin
            state <= COIN_3;
          end
        end
        COIN_3: begin
          // A coin at full credit is swallowed; credit saturates here.
          if (i_sprite) begin
            state    <= COIN_1;
            o_sprite <= 1'b1;
          end else if (i_coffee) begin
            state    <= COIN_2;
            o_coffee <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Affordability LEDs, credit readout and display decode straight from state.
  always_comb begin
    o_led_coffee = (state != IDLE);
    o_led_sprite = (state == COIN_2) || (state == COIN_3);
    BCD_signal   = state;
    o_seg        = SEG_ACTIVE_LOW ? seg_decode(state) : ~seg_decode(state);
  end

endmodule

// File: tb/tb_fsm_vending_machine.sv
// Directed bench for fsm_vending_machine: reset, purchases, insufficient
// credit, coin saturation, simultaneous inputs, reset during a dispense.
module tb_fsm_vending_machine;

  logic       clk = 1'b0;
  logic       rst_n, i_coin, i_coffee, i_sprite;
  logic       o_led_coffee, o_led_sprite, o_coffee, o_sprite;
  logic [1:0] BCD_signal;
  logic [7:0] o_seg;

  logic       cc_led_coffee, cc_led_sprite, cc_coffee, cc_sprite;
  logic [1:0] cc_bcd;
  logic [7:0] cc_seg;

  int tests  = 0;
  int failed = 0;

  logic [7:0] seg_tab [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

  always #5 clk = ~clk;

  fsm_vending_machine #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_coin(i_coin), .i_coffee(i_coffee),
    .i_sprite(i_sprite), .o_led_coffee(o_led_coffee),
    .o_led_sprite(o_led_sprite), .o_coffee(o_coffee), .o_sprite(o_sprite),
    .BCD_signal(BCD_signal), .o_seg(o_seg)
  );

  fsm_vending_machine #(.SEG_ACTIVE_LOW(1'b0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .i_coin(i_coin), .i_coffee(i_coffee),
    .i_sprite(i_sprite), .o_led_coffee(cc_led_coffee),
    .o_led_sprite(cc_led_sprite), .o_coffee(cc_coffee), .o_sprite(cc_sprite),
    .BCD_signal(cc_bcd), .o_seg(cc_seg)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full check of both instances against the expected credit and pulses.
  task automatic expect_all(input string tag, input logic [1:0] bcd,
                            input logic coffee, input logic sprite);
    logic [7:0] seg_exp;
    logic       lc_exp, ls_exp;
    seg_exp = seg_tab[bcd];
    lc_exp  = (bcd != 2'd0);
    ls_exp  = (bcd >= 2'd2);
    chk({tag, ".bcd"},      {6'd0, BCD_signal},   {6'd0, bcd});
    chk({tag, ".seg"},      o_seg,                seg_exp);
    chk({tag, ".led_cof"},  {7'd0, o_led_coffee}, {7'd0, lc_exp});
    chk({tag, ".led_spr"},  {7'd0, o_led_sprite}, {7'd0, ls_exp});
    chk({tag, ".coffee"},   {7'd0, o_coffee},     {7'd0, coffee});
    chk({tag, ".sprite"},   {7'd0, o_sprite},     {7'd0, sprite});
    chk({tag, ".cc_seg"},   cc_seg,               ~seg_exp);
    chk({tag, ".cc_bcd"},   {6'd0, cc_bcd},       {6'd0, bcd});
    chk({tag, ".cc_pulse"}, {6'd0, cc_coffee, cc_sprite}, {6'd0, coffee, sprite});
    chk({tag, ".cc_leds"},  {6'd0, cc_led_coffee, cc_led_sprite}, {6'd0, lc_exp, ls_exp});
  endtask

  // Apply inputs, take one rising edge, settle before sampling.
  task automatic step(input logic r, input logic coin, input logic coffee,
                      input logic sprite);
    rst_n    = r;
    i_coin   = coin;
    i_coffee = coffee;
    i_sprite = sprite;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; i_coin = 1'b0; i_coffee = 1'b0; i_sprite = 1'b0;
    #2;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_all("reset", 2'd0, 0, 0);

    // One coin, then coffee
    step(0, 1, 0, 0); expect_all("coin1", 2'd1, 0, 0);
    step(0, 0, 1, 0); expect_all("coffee1", 2'd0, 1, 0);
    step(0, 0, 0, 0); expect_all("coffee1_end", 2'd0, 0, 0);

    // Two coins, then coffee
    step(0, 1, 0, 0); expect_all("c2a", 2'd1, 0, 0);
    step(0, 1, 0, 0); expect_all("c2b", 2'd2, 0, 0);
    step(0, 0, 1, 0); expect_all("coffee2", 2'd1, 1, 0);
    step(0, 0, 0, 0); expect_all("coffee2_end", 2'd1, 0, 0);

    // From 1: two coins, coffee, coin, sprite
    step(0, 1, 0, 0); expect_all("c3a", 2'd2, 0, 0);
    step(0, 1, 0, 0); expect_all("c3b", 2'd3, 0, 0);
    step(0, 0, 1, 0); expect_all("coffee3", 2'd2, 1, 0);
    step(0, 0, 0, 0); expect_all("coffee3_end", 2'd2, 0, 0);
    step(0, 1, 0, 0); expect_all("c3c", 2'd3, 0, 0);
    step(0, 0, 0, 1); expect_all("sprite3", 2'd1, 0, 1);
    step(0, 0, 0, 0); expect_all("sprite3_end", 2'd1, 0, 0);

    // Insufficient credit
    step(0, 0, 0, 1); expect_all("spr_at1", 2'd1, 0, 0);
    step(0, 0, 1, 0); expect_all("cof_at1", 2'd0, 1, 0);
    step(0, 0, 1, 0); expect_all("cof_at0", 2'd0, 0, 0);
    step(0, 0, 0, 1); expect_all("spr_at0", 2'd0, 0, 0);

    // Coin held five cycles saturates at 3
    step(0, 1, 0, 0); expect_all("hold1", 2'd1, 0, 0);
    step(0, 1, 0, 0); expect_all("hold2", 2'd2, 0, 0);
    step(0, 1, 0, 0); expect_all("hold3", 2'd3, 0, 0);
    step(0, 1, 0, 0); expect_all("hold4", 2'd3, 0, 0);
    step(0, 1, 0, 0); expect_all("hold5", 2'd3, 0, 0);

    // Simultaneous inputs
    step(0, 0, 1, 1); expect_all("spr_cof_at3", 2'd1, 0, 1);
    step(0, 0, 0, 0); expect_all("spr_cof_end", 2'd1, 0, 0);
    step(0, 0, 1, 0); expect_all("to_zero", 2'd0, 1, 0);
    step(0, 1, 1, 0); expect_all("coin_cof_at0", 2'd1, 0, 0);
    step(0, 1, 0, 1); expect_all("coin_spr_at1", 2'd2, 0, 0);
    step(0, 1, 1, 1); expect_all("all_at2", 2'd0, 0, 1);

    // Back-to-back coffee held high at 3
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); expect_all("refill", 2'd3, 0, 0);
    step(0, 0, 1, 0); expect_all("hcof1", 2'd2, 1, 0);
    step(0, 0, 1, 0); expect_all("hcof2", 2'd1, 1, 0);
    step(0, 0, 1, 0); expect_all("hcof3", 2'd0, 1, 0);
    step(0, 0, 1, 0); expect_all("hcof4", 2'd0, 0, 0);

    // Reset on the same edge as a sprite request at full credit
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); expect_all("pre_rst", 2'd3, 0, 0);
    step(1, 0, 0, 1); expect_all("rst_spr", 2'd0, 0, 0);
    step(0, 0, 0, 0); expect_all("post_rst", 2'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fsm_vending_machine.md
Name: fsm_vending_machine

Overview:
Coin-operated drink vending controller with a 7-segment credit display. Credit is held in a 4-state FSM: IDLE=0, COIN_1=1, COIN_2=2, COIN_3=3 coins. Coffee costs 1 coin and sprite costs 2. The top level integrates the credit/dispense FSM and a BCD-to-7-segment decoder; it sits between front-panel buttons and the LED, dispenser and display drivers.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = common-anode segments (0 lights a segment); 0 = inverted (common-cathode).

Ports:
clk  input  1  system clock (50 MHz nominal), all state on rising edge
rst_n  input  1  reset, synchronous, active-high (asserted when 1)
i_coin  input  1  coin inserted; each cycle high = one coin
i_coffee  input  1  coffee request; each cycle high = one request
i_sprite  input  1  sprite request; each cycle high = one request
o_led_coffee  output  1  coffee affordable (credit >= 1)
o_led_sprite  output  1  sprite affordable (credit >= 2)
o_coffee  output  1  one-cycle coffee dispense pulse
o_sprite  output  1  one-cycle sprite dispense pulse
BCD_signal  output  2  current credit 0..3 (state encoding)
o_seg  output  8  7-seg pattern of BCD_signal, bit order {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rst_n=1 at a clk edge): state=IDLE, o_coffee=0, o_sprite=0. This gives BCD_signal=0, both LEDs 0, and o_seg showing "0". Reset overrides all inputs. Reset mid-dispense clears the pending pulse, and the credit is lost.
- Inputs are level-sampled every clock edge, with no edge detection. A cycle in which an input is held high counts as a new event.
- Per edge, at most one action is taken, chosen in this priority:
  1. i_sprite=1 and credit>=2: credit -= 2, o_sprite=1 next cycle.
  2. Else i_coffee=1 and credit>=1: credit -= 1, o_coffee=1 next cycle.
  3. Else i_coin=1 and credit<3: credit += 1.
  4. Else: hold state.
- Unaffordable requests are ignored with no pulse. If a higher-priority request is ignored, the next eligible lower-priority input still applies.
- A coin at COIN_3 is ignored: credit saturates at 3 and does not wrap.
- State transitions:
  - IDLE: coin -> COIN_1.
  - COIN_1: coffee -> IDLE; coin -> COIN_2.
  - COIN_2: sprite -> IDLE; coffee -> COIN_1; coin -> COIN_3.
  - COIN_3: sprite -> COIN_1; coffee -> COIN_2; coin -> hold.
- o_coffee and o_sprite are registered. Each is high exactly one cycle, the cycle after the sampling edge. They are never high simultaneously. Both are 0 on every cycle with no dispense.
- o_led_coffee = (state != IDLE) and o_led_sprite = (state is COIN_2 or COIN_3). Both are decoded combinationally from the state register and update the same edge credit changes.
- BCD_signal = state register (IDLE=2'd0 .. COIN_3=2'd3).
- Segment decoder is combinational from BCD_signal, with dp always off. Active-low values:
  - 0 -> 8'hC0
  - 1 -> 8'hF9
  - 2 -> 8'hA4
  - 3 -> 8'hB0
- With SEG_ACTIVE_LOW=0, o_seg is the bitwise inverse of those values.
- No unreachable states. Any illegal encoding (if state is wider) recovers to IDLE on the next edge.

Test Plan:
- Reset then 1 coin pulse, then 1 coffee pulse:
  - After the coin: BCD=1, o_seg=C0->F9, led_coffee=1, led_sprite=0.
  - After coffee: o_coffee high exactly 1 cycle, BCD=0, both LEDs 0.
- 2 coin pulses, then coffee: BCD 0->1->2 and led_sprite=1 at 2. Coffee gives a 1-cycle o_coffee and BCD=1 (o_seg=F9).
- From BCD=1, 2 more coins: the first gives BCD=2 (A4) and the second BCD=3 (B0). Then coffee gives o_coffee pulse and BCD=2. Then 1 coin gives BCD=3, and sprite gives a 1-cycle o_sprite and BCD=1.
- Insufficient credit: sprite at BCD=1 -> no pulse, BCD stays 1. Coffee or sprite at BCD=0 -> no pulse. Coin held high 5 cycles from 0 -> BCD saturates at 3 and stays there.
- Simultaneous inputs:
  - i_sprite and i_coffee high at BCD=3 -> only o_sprite pulses, BCD=1.
  - i_coin and i_coffee high at BCD=0 -> coin accepted, BCD=1, no pulse.
- Reset asserted at BCD=3 on the same edge as i_sprite -> no o_sprite pulse, BCD=0, o_seg=C0, LEDs 0.
